// File: rtl/ad7606_frame_packer.sv
// ad7606_frame_packer
// Captures complete 8-channel AD7606 conversion frames into a two-slot
// ping-pong buffer and streams each one out as a packet:
//   HEADER, sequence number, enabled channel samples (ascending order).
// Frames arriving while both slots are full are dropped and counted.
module ad7606_frame_packer #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_valid,
    input  logic [DATA_W-1:0] ad_ch1,
    input  logic [DATA_W-1:0] ad_ch2,
    input  logic [DATA_W-1:0] ad_ch3,
    input  logic [DATA_W-1:0] ad_ch4,
    input  logic [DATA_W-1:0] ad_ch5,
    input  logic [DATA_W-1:0] ad_ch6,
    input  logic [DATA_W-1:0] ad_ch7,
    input  logic [DATA_W-1:0] ad_ch8,
    input  logic [7:0]        ch_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [15:0]       overflow_cnt,
    output logic              busy
);

    localparam logic [DATA_W-1:0] HEADER = DATA_W'(16'hA55A);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_SEQ  = 2'd2;
    localparam logic [1:0] S_CH   = 2'd3;

    // Index of the lowest set bit; only meaningful for a non-zero mask.
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Frame storage: two slots, each with samples, mask and sequence number.
    logic [DATA_W-1:0] slot_data [2][8];
    logic [7:0]        slot_en   [2];
    logic [15:0]       slot_seq  [2];

    logic [DATA_W-1:0] samples [8];

    // Control state
    logic [1:0]  state;
    logic [2:0]  ch_idx;
    logic [7:0]  rem_mask;     // enabled channels not yet emitted
    logic [1:0]  occ;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [15:0] seq;

    // Next-state signals
    logic              hs;
    logic              accept;
    logic              drop;
    logic              release_slot;
    logic [7:0]        cur_en;
    logic [1:0]        state_n;
    logic [2:0]        ch_idx_n;
    logic [7:0]        rem_mask_n;
    logic [DATA_W-1:0] data_n;
    logic              valid_n;
    logic              last_n;
    logic [1:0]        occ_n;

    // Gather the channel inputs into an indexable array.
    always_comb begin
        samples[0] = ad_ch1;
        samples[1] = ad_ch2;
        samples[2] = ad_ch3;
        samples[3] = ad_ch4;
        samples[4] = ad_ch5;
        samples[5] = ad_ch6;
        samples[6] = ad_ch7;
        samples[7] = ad_ch8;
    end

    // Packet sequencing, buffer bookkeeping and next output word.
    always_comb begin
        hs           = out_valid && out_ready;
        // Capture decisions use the registered occupancy: a slot freed by
        // this cycle's last-word handshake is not yet available.
        accept       = frame_valid && (occ != 2'd2);
        drop         = frame_valid && (occ == 2'd2);
        cur_en       = slot_en[rd_ptr];
        release_slot = 1'b0;
        state_n      = state;
        ch_idx_n     = ch_idx;
        rem_mask_n   = rem_mask;
        data_n       = out_data;
        valid_n      = out_valid;
        last_n       = out_last;

        case (state)
            S_IDLE: begin
                // A frame written this cycle is already readable next cycle,
                // so the header can go out without waiting for occ to update.
                if ((occ != 2'd0) || accept) begin
                    state_n = S_HDR;
                    data_n  = HEADER;
                    valid_n = 1'b1;
                    last_n  = 1'b0;
                end
            end
            S_HDR: begin
                if (hs) begin
                    state_n = S_SEQ;
                    data_n  = DATA_W'(slot_seq[rd_ptr]);
                    last_n  = (cur_en == 8'd0);
                end
            end
            S_SEQ: begin
                if (hs) begin
                    if (cur_en == 8'd0) begin
                        release_slot = 1'b1;
                    end else begin
                        state_n    = S_CH;
                        ch_idx_n   = lowest_set(cur_en);
                        rem_mask_n = cur_en & ~(8'd1 << ch_idx_n);
                        data_n     = slot_data[rd_ptr][ch_idx_n];
                        last_n     = (rem_mask_n == 8'd0);
                    end
                end
            end
            S_CH: begin
                if (hs) begin
                    if (rem_mask == 8'd0) begin
                        release_slot = 1'b1;
                    end else begin
                        ch_idx_n   = lowest_set(rem_mask);
                        rem_mask_n = rem_mask & ~(8'd1 << ch_idx_n);
                        data_n     = slot_data[rd_ptr][ch_idx_n];
                        last_n     = (rem_mask_n == 8'd0);
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                valid_n = 1'b0;
                last_n  = 1'b0;
            end
        endcase

        // Finishing a packet: chain straight into the next header when the
        // other slot holds a frame (including one captured this cycle).
        if (release_slot) begin
            if ((occ == 2'd2) || accept) begin
                state_n = S_HDR;
                data_n  = HEADER;
                valid_n = 1'b1;
                last_n  = 1'b0;
            end else begin
                state_n = S_IDLE;
                valid_n = 1'b0;
                last_n  = 1'b0;
            end
        end

        occ_n = occ + {1'b0, accept} - {1'b0, release_slot};
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            ch_idx       <= 3'd0;
            rem_mask     <= 8'd0;
            occ          <= 2'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            seq          <= 16'd0;
            overflow_cnt <= 16'd0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state     <= state_n;
            ch_idx    <= ch_idx_n;
            rem_mask  <= rem_mask_n;
            occ       <= occ_n;
            out_data  <= data_n;
            out_valid <= valid_n;
            out_last  <= last_n;
            busy      <= valid_n || (occ_n != 2'd0);
            if (frame_valid) seq <= seq + 16'd1;
            if (drop)         overflow_cnt <= sat_inc16(overflow_cnt);
            if (accept)       wr_ptr <= ~wr_ptr;
            if (release_slot) rd_ptr <= ~rd_ptr;
        end
    end

    // Slot payload storage; contents are only read while the slot is occupied.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < 8; k++) begin
                slot_data[wr_ptr][k] <= samples[k];
            end
            slot_en[wr_ptr]  <= ch_en;
            slot_seq[wr_ptr] <= seq;
        end
    end

endmodule

// File: doc/ad7606_frame_packer.md
# ad7606_frame_packer

Downstream stage of the AD7606 parallel-read controller. Captures each completed 8-channel conversion frame (ad_ch1..ad_ch8 plus a one-cycle frame strobe), buffers up to two frames, and emits them as framed 16-bit packets over a valid/ready stream toward the acquisition card's upload path. Each packet carries a header, a frame sequence number and the enabled channels only. Dropped frames are counted.

## Interface
- HEADER, 16'hA55A, first word of every packet
- clk  in  1  system clock, 50 MHz, shared with the AD7606 controller
- rst  in  1  synchronous reset, active-high
- frame_valid  in  1  one-cycle pulse; ad_ch1..ad_ch8 valid and stable in that cycle
- ad_ch1..ad_ch8  in  16 each  channel samples from the AD7606 controller
- ch_en  in  8  channel enable mask, bit k = ad_ch(k+1); sampled on frame_valid
- out_data  out  16  packet word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts the word when out_valid && out_ready
- out_last  out  1  high with the final word of a packet
- overflow_cnt  out  16  frames dropped for lack of buffer space, saturates at 16'hFFFF
- busy  out  1  out_valid high or any buffer slot occupied

## Operation
- Reset values: out_data 0, out_valid 0, out_last 0, overflow_cnt 0, busy 0; seq counter 0; both slots empty; FSM IDLE.
- Buffer: two slots, ping-pong. Each slot holds 8 samples, captured ch_en, captured seq. Write pointer, read pointer, 2-bit occupancy.
- frame_valid with occupancy < 2 (registered value, before this cycle's update): write slot, occupancy +1.
- frame_valid with occupancy == 2: frame dropped, overflow_cnt +1 (saturating). Slot freed by a last-word handshake in the same cycle is NOT usable by that frame.
- seq increments (16-bit, wraps FFFF->0000) on every frame_valid, accepted or dropped; gaps in seq reveal drops to the host.
- Packet format: HEADER, seq, then samples of enabled channels in ascending channel order. ch_en == 0 gives a 2-word packet with out_last on seq word.
- FSM states: IDLE, HDR, SEQ, CH, with 3-bit channel index.
- IDLE: if occupancy > 0 -> HDR, load out_data=HEADER, out_valid=1.
- HDR -> SEQ on handshake; SEQ -> CH (first enabled channel) on handshake, or release slot if mask empty.
- CH: on handshake advance to next enabled channel via priority search of remaining mask bits; after the highest enabled channel, release slot.
- Release slot: occupancy -1, read pointer toggles; if another slot is occupied go straight to HDR (no idle bubble), else IDLE with out_valid=0.
- Simultaneous frame write and slot release: occupancy unchanged net.
- Stream rules: while out_valid && !out_ready, out_data, out_last hold stable; out_valid never drops without a handshake except on rst.
- rst mid-packet: packet abandoned, no out_last emitted, buffered frames discarded.

## Timing
- All outputs registered.
- frame_valid at cycle T with empty buffer and FSM in IDLE: header visible T+1.
- out_ready held high: packet of N words occupies N consecutive cycles; next buffered packet header follows in the cycle after the last word.
- Worst-case packet 10 words; controller frame period (>30 cycles) absorbed without drops at out_ready=1.
- Slot release visible to the capture logic in the cycle after the last-word handshake.

## Test plan
- ch_en=8'hFF, out_ready=1, frame with ch1..ch8 = 0x0001..0x0008 -> words A55A, 0000, 0001..0008 on cycles T+1..T+10, out_last only on 0008.
- ch_en=8'b1000_0101, ch values 0x1111*k -> A55A, seq, 1111, 3333, 8888, out_last on 8888.
- ch_en=8'h00 -> A55A, seq; out_last on seq word; slot freed, busy falls next cycle.
- out_ready=0 for 200 cycles, three frames arrive -> first word held stable; frames 0,1 buffered, frame 2 dropped, overflow_cnt=1; after release packets carry seq 0000 then 0001; fourth frame carries seq 0003.
- Same-cycle frame_valid and last-word handshake with occupancy 2 -> frame dropped, overflow_cnt increments; with occupancy 1 -> frame accepted, occupancy stays 1, next header immediately follows.
- rst asserted mid-packet -> next cycle all outputs at reset values; following frame emits seq 0000.
